pipelined_cla_addsub: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready stream interface.
- Successor to the team's fixed 16-bit two-level CLA: width is generic, and pipeline registers are inserted every SEG_W bits.
- Adds subtraction, carry-in, signed overflow and zero flags.
- Sits in front of the ALU datapath and the accumulator blocks wherever operands arrive as a stream.

---
 rtl/pipelined_cla_addsub.sv | 180 ++++++++++++++++++
 tb/tb_pipelined_cla_addsub.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_addsub.sv
// Streamed add/subtract, WIDTH/SEG_W-cycle latency, one segment of carry-lookahead per stage.
// Global stall: every stage holds while a result waits unaccepted. ADDER_SAT_EN builds signed saturation.
module pipelined_cla_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int L  = WIDTH / SEG_W;
  localparam int NG = SEG_W / 4;

  typedef struct packed {
    logic [SEG_W-1:0] sum;
    logic             c_msb;
    logic             cout;
  } seg_res_t;

  // Group generate/propagate per nibble, then flattened lookahead across groups and within each group.
  function automatic seg_res_t cla_seg(input logic [SEG_W-1:0] x,
                                       input logic [SEG_W-1:0] y,
                                       input logic             cin);
    seg_res_t         r;
    logic [SEG_W-1:0] g;
    logic [SEG_W-1:0] p;
    logic [SEG_W-1:0] c;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic [NG:0]      gc;
    logic [NG:0]      gsrc;
    logic [3:0]       bsrc;
    logic             term;
    g = x & y;
    p = x | y;
    c = '0;
    for (int j = 0; j < NG; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    gsrc = {gg, cin};
    gc   = '0;
    gc[0] = cin;
    for (int j = 1; j <= NG; j++) begin
      for (int i = 0; i <= j; i++) begin
        term = gsrc[i];
        for (int m = i; m < j; m++) term = term & gp[m];
        gc[j] = gc[j] | term;
      end
    end
    for (int j = 0; j < NG; j++) begin
      bsrc = {g[4*j +: 3], gc[j]};
      for (int t = 0; t < 4; t++) begin
        for (int i = 0; i <= t; i++) begin
          term = bsrc[i];
          for (int m = i; m < t; m++) term = term & p[4*j+m];
          c[4*j+t] = c[4*j+t] | term;
        end
      end
    end
    r.sum   = x ^ y ^ c;
    r.c_msb = c[SEG_W-1];
    r.cout  = gc[NG];
    return r;
  endfunction

  logic en;

  for (genvar k = 0; k < L; k++) begin : g_stage
    logic             vld_in;
    logic             cin;
    logic             sat_in;
    logic [WIDTH-1:0] opa_in;
    logic [WIDTH-1:0] opb_in;
    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] res_d;
    seg_res_t         seg;
    logic             vld_q;
    logic             cy_q;
    logic             sat_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] sum_q;
    logic             unused_ops;

    if (k == 0) begin : g_head
      assign vld_in = in_valid & en;
      assign opa_in = a;
      assign opb_in = b ^ {WIDTH{sub}};
      assign cin    = ci;
      assign sat_in = sat;
      assign sum_in = '0;
    end else begin : g_body
      assign vld_in = g_stage[k-1].vld_q;
      assign opa_in = g_stage[k-1].opa_q;
      assign opb_in = g_stage[k-1].opb_q;
      assign cin    = g_stage[k-1].cy_q;
      assign sat_in = g_stage[k-1].sat_q;
      assign sum_in = g_stage[k-1].sum_q;
    end

    assign seg = cla_seg(opa_in[k*SEG_W +: SEG_W], opb_in[k*SEG_W +: SEG_W], cin);

    always_comb begin
      sum_d = sum_in;
      sum_d[k*SEG_W +: SEG_W] = seg.sum;
    end

    if (k == L-1) begin : g_tail
      logic ovf_d;
      logic ovf_q;
      logic zero_q;
      assign ovf_d = seg.c_msb ^ seg.cout;
`ifdef ADDER_SAT_EN
      // Overflow implies both operands share a sign, so a's MSB picks the clamp direction.
      assign res_d = (sat_in && ovf_d) ?
                     (opa_in[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) :
                     sum_d;
`else
      assign res_d = sum_d;
`endif
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (en) begin
          ovf_q  <= ovf_d;
          zero_q <= (res_d == '0);
        end
      end
    end else begin : g_pass
      assign res_d = sum_d;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        sat_q <= 1'b0;
        opa_q <= '0;
        opb_q <= '0;
        sum_q <= '0;
      end else if (en) begin
        vld_q <= vld_in;
        cy_q  <= seg.cout;
        sat_q <= sat_in;
        opa_q <= opa_in;
        opb_q <= opb_in;
        sum_q <= res_d;
      end
    end

    // Consumed segments and the final stage's operand copies are dead by design.
    assign unused_ops = ^{opa_in, opb_in, opa_q, opb_q, sat_q, seg};
  end

  assign out_valid = g_stage[L-1].vld_q;
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign s         = g_stage[L-1].sum_q;
  assign co        = g_stage[L-1].cy_q;
  assign ovf       = g_stage[L-1].g_tail.ovf_q;
  assign zero      = g_stage[L-1].g_tail.zero_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboarded bench for pipelined_cla_addsub: directed corners, stall, reset flush, random stream.
module tb_pipelined_cla_addsub;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        ci;
  logic        sub;
  logic        sat;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
  logic        co;
  logic        ovf;
  logic        zero;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_popped = 0;
  bit   rnd_on   = 0;

  pipelined_cla_addsub #(.WIDTH(32), .SEG_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co), .ovf(ovf), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp_v);
    end
  endtask

  // Reference: plain two's-complement arithmetic on a 33-bit sum.
  function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb_v,
                                 input logic tci, input logic tsub, input logic tsat);
    exp_t        e;
    logic [31:0] bb;
    logic [32:0] full;
    bb     = tsub ? ~tb_v : tb_v;
    full   = {1'b0, ta} + {1'b0, bb} + {32'd0, tci};
    e.co   = full[32];
    e.s    = full[31:0];
    e.ovf  = (ta[31] == bb[31]) && (full[31] != ta[31]);
`ifdef ADDER_SAT_EN
    if (tsat && e.ovf) e.s = ta[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
    if (tsat && 1'b0) e.s = 32'd0;
`endif
    e.zero = (e.s == 32'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_v,
                      input logic tci, input logic tsub, input logic tsat);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    a = ta; b = tb_v; ci = tci; sub = tsub; sat = tsat;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk1("send_accept_timeout", in_ready, 1'b1);
    end else begin
      sbq.push_back(model(ta, tb_v, tci, tsub, tsat));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sbq.size() != 0 && g < 100) begin
      @(posedge clk);
      g++;
    end
    chk32("drain_queue_empty", 32'(sbq.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: a result transfers on the next rising edge when valid and ready are both high.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got s=%h with no transaction pending", s);
      end else begin
        e = sbq.pop_front();
        chk32("s", s, e.s);
        chk1("co", co, e.co);
        chk1("ovf", ovf, e.ovf);
        chk1("zero", zero, e.zero);
        n_popped++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    int          g;
    int          rem;
    logic [31:0] held;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    ci = 1'b0; sub = 1'b0; sat = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk1("reset_out_valid", out_valid, 1'b0);
    chk1("reset_in_ready", in_ready, 1'b1);
    chk32("reset_s", s, 32'd0);
    chk1("reset_co", co, 1'b0);
    chk1("reset_ovf", ovf, 1'b0);
    chk1("reset_zero", zero, 1'b0);
    @(posedge clk);
    #1;

    // Directed corners, with a latency probe on the first one.
    send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk1("latency_not_yet", out_valid, 1'b0);
    @(negedge clk);
    chk1("latency_two", out_valid, 1'b1);
    @(posedge clk);
    #1;
    send(32'd5, 32'd7, 1'b1, 1'b1, 1'b0);
    send(32'd7, 32'd5, 1'b1, 1'b1, 1'b0);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b1);
    send(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
    drain();

    // Six back-to-back transactions with a three-cycle downstream stall.
    base = n_popped;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      end
      begin
        g = 0;
        while (n_popped < base + 1 && g < 100) begin
          @(posedge clk);
          g++;
        end
        chk1("stall_first_result_seen", n_popped >= base + 1, 1'b1);
        #1;
        out_ready = 1'b0;
        held = s;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk1("stall_in_ready_low", in_ready, 1'b0);
          chk1("stall_out_valid_held", out_valid, 1'b1);
          chk32("stall_s_stable", s, held);
          @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        rem = 6 - (n_popped - base);
        for (int i = 0; i < rem; i++) begin
          @(negedge clk);
          chk1("stall_no_gap", out_valid, 1'b1);
          @(posedge clk);
        end
        #1;
      end
    join
    drain();
    chk32("stall_result_count", 32'(n_popped - base), 32'd6);

    // Random stream with random downstream backpressure.
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          if (rnd_on) out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 200; i++) begin
      send(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_on = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    // Reset with two transactions in flight: both must vanish.
    out_ready = 1'b0;
    send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    send(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk1("flush_pre_out_valid", out_valid, 1'b1);
    @(posedge clk);
    #1;
    sbq.delete();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk1("flush_out_valid", out_valid, 1'b0);
    chk32("flush_s", s, 32'd0);
    chk1("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk32("final_queue_empty", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
